// File: rtl/pipelined_slice_alu.sv
// WIDTH-bit ALU assembled from 4-bit function slices, one pipeline stage per slice.
// Carry ripples between stages through registers; results are de-skewed so a beat leaves in one piece.
module pipelined_slice_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             M,
    input  logic             Pin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             Pout,
    output logic             zero,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / 4;

    logic                   adv;
    logic [NSLICE-1:0]      v_q, v_d;
    logic [NSLICE-1:0]      m_q, m_d;
    logic [NSLICE-1:0]      c_q, c_d;
    logic [WIDTH-1:0]       a_q   [NSLICE];
    logic [WIDTH-1:0]       a_d   [NSLICE];
    logic [WIDTH-1:0]       b_q   [NSLICE];
    logic [WIDTH-1:0]       b_d   [NSLICE];
    logic [WIDTH-1:0]       res_q [NSLICE];
    logic [WIDTH-1:0]       res_d [NSLICE];
    logic [3:0]             s_q   [NSLICE];
    logic [3:0]             s_d   [NSLICE];

    logic [3:0]             f     [NSLICE];
    logic [NSLICE-1:0]      co;
    logic [NSLICE-1:0]      c3;
    logic [5:0]             sl;
    logic [WIDTH-1:0]       r_full;

    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       r_q, r_d;
    logic                   pout_q, pout_d;
    logic                   zero_q, zero_d;
    logic                   ovf_q, ovf_d;

    // Each slice adds an "or" term and an "and" term selected by S; logic mode is their XNOR.
    // Returns {carry_out, carry_into_bit3, f}.
    function automatic logic [5:0] slice_fn(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] s, input logic m, input logic cin);
        logic [3:0] o_t;
        logic [3:0] n_t;
        logic [4:0] sum;
        o_t = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        n_t = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        sum = {1'b0, o_t} + {1'b0, n_t} + {4'b0000, cin};
        if (m)
            slice_fn = {2'b00, ~(o_t ^ n_t)};
        else
            slice_fn = {sum[4], sum[3] ^ o_t[3] ^ n_t[3], sum[3:0]};
    endfunction

    always_comb begin
        adv   = !out_valid_q || out_ready;
        v_d   = v_q;
        m_d   = m_q;
        c_d   = c_q;
        co    = '0;
        c3    = '0;
        sl    = '0;
        for (int unsigned k = 0; k < NSLICE; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            s_d[k]   = s_q[k];
            res_d[k] = res_q[k];
            sl       = slice_fn(a_q[k][4*k +: 4], b_q[k][4*k +: 4], s_q[k], m_q[k], c_q[k]);
            co[k]    = sl[5];
            c3[k]    = sl[4];
            f[k]     = sl[3:0];
        end

        if (adv) begin
            v_d[0]   = in_valid;
            a_d[0]   = A;
            b_d[0]   = B;
            s_d[0]   = S;
            m_d[0]   = M;
            c_d[0]   = Pin;
            res_d[0] = '0;
            // Operands travel whole; each stage appends its finished nibble to the partial result.
            for (int unsigned k = 1; k < NSLICE; k++) begin
                v_d[k]   = v_q[k-1];
                a_d[k]   = a_q[k-1];
                b_d[k]   = b_q[k-1];
                s_d[k]   = s_q[k-1];
                m_d[k]   = m_q[k-1];
                c_d[k]   = co[k-1];
                res_d[k] = res_q[k-1];
                res_d[k][4*(k-1) +: 4] = f[k-1];
            end
        end

        r_full = res_q[NSLICE-1];
        r_full[4*(NSLICE-1) +: 4] = f[NSLICE-1];

        out_valid_d = adv ? v_q[NSLICE-1] : out_valid_q;
        r_d         = r_q;
        pout_d      = pout_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        if (adv && v_q[NSLICE-1]) begin
            r_d    = r_full;
            pout_d = co[NSLICE-1];
            zero_d = ~|r_full;
            ovf_d  = co[NSLICE-1] ^ c3[NSLICE-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q         <= '0;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            pout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            pout_q      <= pout_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        m_q   <= m_d;
        c_q   <= c_d;
        a_q   <= a_d;
        b_q   <= b_d;
        s_q   <= s_d;
        res_q <= res_d;
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign R         = r_q;
    assign Pout      = pout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule
